// File: rtl/aes_key_sch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_key_sch_arbiter                                                        |
// | Round-robin share of one AES-256 key schedule between the XTS data key and |
// | tweak key; streams registered, step-tagged round-key groups to the owner.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_key_sch_arbiter #(
   parameter int NUM_STEPS = 8,
   parameter int STEP_W    = 3,
   parameter int WAIT_MAX  = 2
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic [1:0]        inReq,
   input  logic [255:0]      inKey0,
   input  logic [255:0]      inKey1,
   output logic [1:0]        outGnt,
   output logic              outKeySchWr,
   output logic [255:0]      outKeySchKey,
   input  logic              inKeySchBusy,
   input  logic [255:0]      inKeySchRoundKey,
   output logic [255:0]      outRoundKey,
   output logic              outRoundKeyValid,
   output logic [STEP_W-1:0] outStep,
   output logic              outOwner,
   output logic [1:0]        outDone,
   output logic              outErr
);

   // One extra bit so the counter can express "all groups already forwarded".
   localparam int CNT_W  = STEP_W + 1;
   localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WAIT   = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q,   state_d;
   logic                owner_q,   owner_d;
   logic                last_q,    last_d;
   logic [CNT_W-1:0]    step_q,    step_d;
   logic [WAIT_W-1:0]   wait_q,    wait_d;
   logic [255:0]        rk_q,      rk_d;
   logic [STEP_W-1:0]   rkStep_q,  rkStep_d;
   logic                rkVld_q,   rkVld_d;

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         step_q   <= '0;
         wait_q   <= '0;
         rk_q     <= '0;
         rkStep_q <= '0;
         rkVld_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         step_q   <= step_d;
         wait_q   <= wait_d;
         rk_q     <= rk_d;
         rkStep_q <= rkStep_d;
         rkVld_q  <= rkVld_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      step_d       = step_q;
      wait_d       = wait_q;
      rk_d         = rk_q;
      rkStep_d     = rkStep_q;
      rkVld_d      = 1'b0;
      outGnt       = 2'b00;
      outKeySchWr  = 1'b0;
      outKeySchKey = '0;
      outDone      = 2'b00;
      outErr       = 1'b0;

      if (state_q != S_IDLE) begin
         outGnt = owner_q ? 2'b10 : 2'b01;
      end

      case (state_q)
         S_IDLE: begin
            // On contention the requester that was not served last wins.
            if (inReq != 2'b00) begin
               owner_d = (inReq == 2'b11) ? ~last_q : inReq[1];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            outKeySchWr  = 1'b1;
            outKeySchKey = owner_q ? inKey1 : inKey0;
            step_d       = '0;
            wait_d       = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (inKeySchBusy) begin
               rk_d     = inKeySchRoundKey;
               rkStep_d = '0;
               rkVld_d  = 1'b1;
               step_d   = CNT_W'(1);
               state_d  = S_STREAM;
            end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
               outErr  = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_STREAM: begin
            if (!inKeySchBusy) begin
               state_d = S_DONE;
            end else if (step_q == CNT_W'(NUM_STEPS)) begin
               outErr  = 1'b1;
               state_d = S_DONE;
            end else begin
               rk_d     = inKeySchRoundKey;
               rkStep_d = step_q[STEP_W-1:0];
               rkVld_d  = 1'b1;
               step_d   = step_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            outDone = owner_q ? 2'b10 : 2'b01;
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign outRoundKey      = rk_q;
   assign outRoundKeyValid = rkVld_q;
   assign outStep          = rkStep_q;
   assign outOwner         = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_key_sch_arbiter                                                     |
// | Directed bench with a behavioural key-schedule model for the arbiter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_key_sch_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    inReq = 2'b00;
   logic [255:0]  inKey0 = '0;
   logic [255:0]  inKey1 = '0;
   logic [1:0]    outGnt;
   logic          outKeySchWr;
   logic [255:0]  outKeySchKey;
   logic          busy_m = 1'b0;
   logic [255:0]  rk_m = '0;
   logic [255:0]  outRoundKey;
   logic          outRoundKeyValid;
   logic [2:0]    outStep;
   logic          outOwner;
   logic [1:0]    outDone;
   logic          outErr;

   always #5 clk = ~clk;

   aes_key_sch_arbiter #(.NUM_STEPS(8), .STEP_W(3), .WAIT_MAX(2)) dut (
      .inClk            (clk),
      .inRstN           (rst_n),
      .inReq            (inReq),
      .inKey0           (inKey0),
      .inKey1           (inKey1),
      .outGnt           (outGnt),
      .outKeySchWr      (outKeySchWr),
      .outKeySchKey     (outKeySchKey),
      .inKeySchBusy     (busy_m),
      .inKeySchRoundKey (rk_m),
      .outRoundKey      (outRoundKey),
      .outRoundKeyValid (outRoundKeyValid),
      .outStep          (outStep),
      .outOwner         (outOwner),
      .outDone          (outDone),
      .outErr           (outErr)
   );

   // Key-schedule model: busy for sch_len cycles starting the cycle after the
   // load strobe; group k is (loaded key + k), so group 0 is the raw key.
   int           sch_len = 8;
   int           rem = 0;
   int           idx = 0;
   bit           arm = 1'b0;
   int           wr_cnt = 0;
   logic [255:0] wr_key = '0;

   always @(negedge clk) begin
      if (outKeySchWr === 1'b1) begin
         arm    = 1'b1;
         wr_key = outKeySchKey;
         wr_cnt++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (arm) begin
         arm = 1'b0;
         idx = 0;
         rem = sch_len;
      end
      if (rem > 0) begin
         busy_m = 1'b1;
         rk_m   = wr_key + 256'(idx);
         idx++;
         rem--;
      end else begin
         busy_m = 1'b0;
         rk_m   = '0;
      end
   end

   // Output monitor.
   logic [2:0]   q_step[$];
   logic [255:0] q_data[$];
   int           err_cnt = 0;
   int           done_cnt = 0;
   int           gnt_bad = 0;

   always @(negedge clk) begin
      if (outRoundKeyValid === 1'b1) begin
         q_step.push_back(outStep);
         q_data.push_back(outRoundKey);
      end
      if (outErr === 1'b1) err_cnt++;
      if (outDone !== 2'b00) done_cnt++;
      if (outGnt === 2'b11) gnt_bad++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      q_step.delete();
      q_data.delete();
      err_cnt  = 0;
      done_cnt = 0;
      wr_cnt   = 0;
   endtask

   task automatic wait_done(output logic [1:0] d);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (outDone === 2'b00 && n < 40);
      d = outDone;
   endtask

   task automatic chk_stream(input string tag, input logic [255:0] key);
      chk({tag, "_nvalid"}, 256'(q_step.size()), 256'd8);
      for (int i = 0; i < 8 && i < q_step.size(); i++) begin
         chk({tag, "_step"}, 256'(q_step[i]), 256'(i));
         chk({tag, "_data"}, q_data[i], key + 256'(i));
      end
   endtask

   localparam logic [255:0] K0 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] K1 = {8{32'hcafef00d}};

   initial begin
      logic [1:0] d;
      int         n;
      bit         found;

      // Reset state
      tick();
      chk("rst_gnt",   256'(outGnt), 256'd0);
      chk("rst_wr",    256'(outKeySchWr), 256'd0);
      chk("rst_valid", 256'(outRoundKeyValid), 256'd0);
      chk("rst_rk",    outRoundKey, 256'd0);
      chk("rst_step",  256'(outStep), 256'd0);
      chk("rst_done",  256'(outDone), 256'd0);
      chk("rst_err",   256'(outErr), 256'd0);
      chk("rst_owner", 256'(outOwner), 256'd0);
      rst_n = 1'b1;
      tick();

      // 1: requester 0 alone
      inKey0  = K0;
      sch_len = 8;
      clr_mon();
      inReq = 2'b01;
      tick();
      chk("t1_gnt",  256'(outGnt), 256'd1);
      chk("t1_wr",   256'(outKeySchWr), 256'd1);
      chk("t1_key",  outKeySchKey, K0);
      tick();
      chk("t1_novalid_wait", 256'(outRoundKeyValid), 256'd0);
      tick();
      chk("t1_first_valid", 256'(outRoundKeyValid), 256'd1);
      chk("t1_first_step",  256'(outStep), 256'd0);
      chk("t1_first_data",  outRoundKey, K0);
      wait_done(d);
      chk("t1_done", 256'(d), 256'd1);
      inReq = 2'b00;
      repeat (3) tick();
      chk("t1_wr_cnt", 256'(wr_cnt), 256'd1);
      chk("t1_wr_key", wr_key, K0);
      chk("t1_err_cnt", 256'(err_cnt), 256'd0);
      chk_stream("t1", K0);

      // 2: both requesters from reset, round-robin
      rst_n = 1'b0;
      inKey1 = K1;
      tick();
      clr_mon();
      inReq = 2'b11;
      rst_n = 1'b1;
      wait_done(d);
      chk("t2_done_a", 256'(d), 256'd1);
      inReq = 2'b10;
      tick();
      chk("t2_gap_gnt", 256'(outGnt), 256'd0);
      wait_done(d);
      chk("t2_done_b", 256'(d), 256'd2);
      chk("t2_owner_b", 256'(outOwner), 256'd1);
      inReq = 2'b11;
      wait_done(d);
      chk("t2_done_c", 256'(d), 256'd1);
      inReq = 2'b00;
      repeat (3) tick();
      chk("t2_gnt_never_11", 256'(gnt_bad), 256'd0);
      chk("t2_done_cnt", 256'(done_cnt), 256'd3);

      // 3: schedule never goes busy
      sch_len = 0;
      clr_mon();
      inReq = 2'b01;
      tick();
      chk("t3_wr", 256'(outKeySchWr), 256'd1);
      tick();
      chk("t3_err_early", 256'(outErr), 256'd0);
      tick();
      chk("t3_err", 256'(outErr), 256'd1);
      tick();
      chk("t3_done", 256'(outDone), 256'd1);
      inReq = 2'b00;
      tick();
      chk("t3_idle_gnt", 256'(outGnt), 256'd0);
      chk("t3_nvalid", 256'(q_step.size()), 256'd0);
      chk("t3_err_cnt", 256'(err_cnt), 256'd1);

      // 4: busy held too long
      sch_len = 10;
      clr_mon();
      inReq = 2'b01;
      wait_done(d);
      chk("t4_done", 256'(d), 256'd1);
      inReq = 2'b00;
      repeat (4) tick();
      chk("t4_err_cnt", 256'(err_cnt), 256'd1);
      chk("t4_done_cnt", 256'(done_cnt), 256'd1);
      chk_stream("t4", K0);

      // 5: asynchronous reset mid-stream
      sch_len = 8;
      clr_mon();
      inReq = 2'b01;
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         tick();
         n++;
         if (outRoundKeyValid === 1'b1 && outStep === 3'd3) found = 1'b1;
      end
      chk("t5_reached_step3", 256'(found), 256'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 256'(outRoundKeyValid), 256'd0);
      chk("t5_async_gnt",   256'(outGnt), 256'd0);
      chk("t5_async_step",  256'(outStep), 256'd0);
      chk("t5_async_rk",    outRoundKey, 256'd0);
      repeat (10) tick();
      chk("t5_no_done", 256'(done_cnt), 256'd0);
      clr_mon();
      rst_n = 1'b1;
      wait_done(d);
      chk("t5_done_after", 256'(d), 256'd1);
      inReq = 2'b00;
      repeat (3) tick();
      chk_stream("t5", K0);

      // 6: requester 1 drops request and changes key mid-stream
      clr_mon();
      inKey1 = K1;
      inReq = 2'b10;
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         tick();
         n++;
         if (outRoundKeyValid === 1'b1 && outStep === 3'd2) found = 1'b1;
      end
      chk("t6_reached_step2", 256'(found), 256'd1);
      inReq  = 2'b00;
      inKey1 = ~K1;
      wait_done(d);
      chk("t6_done", 256'(d), 256'd2);
      repeat (3) tick();
      chk("t6_wr_key", wr_key, K1);
      chk_stream("t6", K1);
      chk("t6_gnt_never_11", 256'(gnt_bad), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
